load_store_unit: RTL

//  Multi-cycle load/store unit feeding Memory_Top's data-memory port in the multi-stage RV32I core.

---
 rtl/lsu_pkg.sv | 17 +
 rtl/lsu_if.sv | 13 +
 rtl/lsu_align.sv | 59 +++++
 rtl/load_store_unit.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: funct3 encodings, FSM states, error codes.
package lsu_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
endpackage

// File: rtl/lsu_if.sv
// Word-aligned data-memory bus: request held until ack, rdata valid with ack.
interface lsu_if #(parameter int XLEN = 32);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [3:0]      wstrb;
  logic            ack;
  logic [XLEN-1:0] rdata;

  modport master (output req, we, addr, wdata, wstrb, input ack, rdata);
  modport slave  (input req, we, addr, wdata, wstrb, output ack, rdata);
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobes/replicated data, misalignment detect, load extract/extend.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      wstrb,
  output logic [XLEN-1:0] wdata_lane,
  output logic            misaligned,
  output logic [XLEN-1:0] rdata_ext
);
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = rdata[{addr_lo, 3'b000} +: 8];
  assign rhalf = rdata[{addr_lo[1], 4'b0000} +: 16];

  // Store lanes and alignment check; funct3[1:0] carries the access size.
  always_comb begin
    wstrb      = 4'b0000;
    wdata_lane = wdata;
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        wstrb      = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
      end
      2'b01: begin
        wstrb      = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_lane = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
      end
      2'b10: begin
        wstrb      = 4'b1111;
        misaligned = (addr_lo != 2'b00);
      end
      default: misaligned = 1'b1;
    endcase
    // 110/111 are not RV32I memory ops; report them like a misaligned access
    if (funct3[2] && funct3[1]) misaligned = 1'b1;
  end

  // Load data extract with sign/zero extension.
  always_comb begin
    rdata_ext = '0;
    case (funct3)
      F3_LB:   rdata_ext = {{(XLEN-8){rbyte[7]}}, rbyte};
      F3_LH:   rdata_ext = {{(XLEN-16){rhalf[15]}}, rhalf};
      F3_LW:   rdata_ext = rdata;
      F3_LBU:  rdata_ext = {{(XLEN-8){1'b0}}, rbyte};
      F3_LHU:  rdata_ext = {{(XLEN-16){1'b0}}, rhalf};
      default: rdata_ext = '0;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit: accepts one op, runs one bus transaction, returns to writeback.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_load,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [4:0]      in_rd,
  lsu_if.master           mem,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic [1:0]      wb_err
);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t          state, state_d;
  logic [CW-1:0]   cnt;
  logic            op_load;
  logic [2:0]      op_f3;
  logic [1:0]      op_lo;
  logic            accept, done_ok, tmo;
  logic [2:0]      a_f3;
  logic [1:0]      a_lo;
  logic [3:0]      lane_wstrb;
  logic [XLEN-1:0] lane_wdata, rdata_ext;
  logic            misaligned;

  // IDLE decodes the incoming op; afterwards the captured op drives load extraction.
  assign a_f3     = (state == S_IDLE) ? in_funct3 : op_f3;
  assign a_lo     = (state == S_IDLE) ? in_addr[1:0] : op_lo;
  assign in_ready = (state == S_IDLE);

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3     (a_f3),
    .addr_lo    (a_lo),
    .wdata      (in_wdata),
    .rdata      (mem.rdata),
    .wstrb      (lane_wstrb),
    .wdata_lane (lane_wdata),
    .misaligned (misaligned),
    .rdata_ext  (rdata_ext)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_d;
  end

  // Next state and per-cycle events; cnt counts elapsed unacked REQ cycles,
  // so the TIMEOUT-th REQ cycle is the last one and an ack there still wins.
  always_comb begin
    state_d = state;
    accept  = 1'b0;
    done_ok = 1'b0;
    tmo     = 1'b0;
    case (state)
      S_IDLE: if (in_valid) begin
        accept  = 1'b1;
        state_d = misaligned ? S_RESP : S_REQ;
      end
      S_REQ: begin
        if (mem.ack) begin
          done_ok = 1'b1;
          state_d = S_RESP;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          tmo     = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP:  if (wb_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered bus and writeback outputs plus captured op fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      op_load   <= 1'b0;
      op_f3     <= '0;
      op_lo     <= '0;
      mem.req   <= 1'b0;
      mem.we    <= 1'b0;
      mem.addr  <= '0;
      mem.wdata <= '0;
      mem.wstrb <= 4'b0000;
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      wb_err    <= ERR_OK;
    end else begin
      if (accept) begin
        op_load <= in_load;
        op_f3   <= in_funct3;
        op_lo   <= in_addr[1:0];
        wb_rd   <= in_rd;
        wb_data <= '0;
        wb_we   <= 1'b0;
        if (misaligned) begin
          wb_err   <= ERR_MISALIGN;
          wb_valid <= 1'b1;
        end else begin
          wb_err    <= ERR_OK;
          mem.req   <= 1'b1;
          mem.we    <= !in_load;
          mem.addr  <= {in_addr[XLEN-1:2], 2'b00};
          mem.wdata <= in_load ? '0 : lane_wdata;
          mem.wstrb <= in_load ? 4'b0000 : lane_wstrb;
        end
      end
      if (state == S_REQ) begin
        if (done_ok || tmo) begin
          cnt       <= '0;
          mem.req   <= 1'b0;
          mem.we    <= 1'b0;
          mem.wstrb <= 4'b0000;
          wb_valid  <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        if (done_ok) begin
          wb_data <= op_load ? rdata_ext : '0;
          wb_we   <= op_load;
        end
        if (tmo) wb_err <= ERR_TIMEOUT;
      end
      if (state == S_RESP && wb_ready) begin
        wb_valid <= 1'b0;
        wb_we    <= 1'b0;
      end
    end
  end
endmodule
